// File: rtl/sw_pe_affine_pkg.sv
// rtl/sw_pe_affine_pkg.sv - shared widths, state and trace encodings for the affine SW PE
package sw_pe_affine_pkg;

  localparam int CALC_W_DEF = 10;
  localparam int SYM_W_DEF  = 2;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_LOADED = 2'd1,
    ST_RUN    = 2'd2
  } pe_state_t;

  typedef enum logic [1:0] {
    SRC_ZERO = 2'd0,
    SRC_DIAG = 2'd1,
    SRC_E    = 2'd2,
    SRC_F    = 2'd3
  } h_src_t;

  // Most negative two's-complement value of a w-bit score, sign-extended to 32 bits.
  function automatic logic signed [31:0] neg_inf(input int w);
    return 32'sh8000_0000 >>> (32 - w);
  endfunction

endpackage

// File: rtl/sw_pe_affine_if.sv
// rtl/sw_pe_affine_if.sv - one PE-to-PE link: query fill chain, target beat, scores, best-score chain
interface sw_pe_affine_if #(
  parameter int CALC_W = 10,
  parameter int SYM_W  = 2,
  parameter int ROW_W  = 16,
  parameter int COL_W  = 10
);
  logic                     q_valid;
  logic [SYM_W-1:0]         q_sym;
  logic                     t_valid;
  logic [SYM_W-1:0]         t_sym;
  logic                     t_last;
  logic signed [CALC_W-1:0] h;
  logic signed [CALC_W-1:0] e;
  logic signed [CALC_W-1:0] max;
  logic [ROW_W-1:0]         max_row;
  logic [COL_W-1:0]         max_col;

  modport master (output q_valid, q_sym, t_valid, t_sym, t_last, h, e, max, max_row, max_col);
  modport slave  (input  q_valid, q_sym, t_valid, t_sym, t_last, h, e, max, max_row, max_col);
endinterface

// File: rtl/sw_sat_add.sv
// rtl/sw_sat_add.sv - signed adder clamping to the W-bit two's-complement range
module sw_sat_add #(
  parameter int W = 10
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] y
);
  logic signed [W:0] sum;

  assign sum = {a[W-1], a} + {b[W-1], b};

  always_comb begin
    y = sum[W-1:0];
    if (sum[W] != sum[W-1])
      y = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  end
endmodule

// File: rtl/sw_pe_affine.sv
// rtl/sw_pe_affine.sv - systolic Smith-Waterman PE with affine gaps and best-score tracking
// Optional SW_PE_TRACE_EN adds trace_o (H source and gap-open flags).
module sw_pe_affine
  import sw_pe_affine_pkg::*;
#(
  parameter int CALC_W  = CALC_W_DEF,
  parameter int SYM_W   = SYM_W_DEF,
  parameter int ROW_W   = 16,
  parameter int COL_IDX = 0,
  parameter int COL_W   = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear_i,
  input  logic signed [CALC_W-1:0] match_i,
  input  logic signed [CALC_W-1:0] mismatch_i,
  input  logic signed [CALC_W-1:0] gap_open_i,
  input  logic signed [CALC_W-1:0] gap_ext_i,
  sw_pe_affine_if.slave            left,
  sw_pe_affine_if.master           right
`ifdef SW_PE_TRACE_EN
  ,
  output logic [3:0]               trace_o
`endif
);
  localparam logic signed [CALC_W-1:0] NEG_INF = CALC_W'(neg_inf(CALC_W));
  localparam logic signed [CALC_W-1:0] ZERO    = '0;
  localparam logic [COL_W-1:0]         COL_ID  = COL_W'(COL_IDX);

  pe_state_t                state, state_nx;
  logic [SYM_W-1:0]         q_sym_r;
  logic signed [CALC_W-1:0] h_diag, h_up, f_up, best, best_nx;
  logic [ROW_W-1:0]         row_cnt, best_row, best_row_nx;
  logic signed [CALC_W-1:0] s, diag, e_open, e_ext, f_open, f_ext, e_val, f_val, h_val;
  logic                     beat;

  assign beat = left.t_valid && (state != ST_EMPTY);
  assign s    = (left.t_sym == q_sym_r) ? match_i : mismatch_i;

  sw_sat_add #(.W(CALC_W)) u_add_diag   (.a(h_diag), .b(s),          .y(diag));
  sw_sat_add #(.W(CALC_W)) u_add_e_open (.a(left.h), .b(gap_open_i), .y(e_open));
  sw_sat_add #(.W(CALC_W)) u_add_e_ext  (.a(left.e), .b(gap_ext_i),  .y(e_ext));
  sw_sat_add #(.W(CALC_W)) u_add_f_open (.a(h_up),   .b(gap_open_i), .y(f_open));
  sw_sat_add #(.W(CALC_W)) u_add_f_ext  (.a(f_up),   .b(gap_ext_i),  .y(f_ext));

  always_comb begin
    e_val = (e_open >= e_ext) ? e_open : e_ext;
    f_val = (f_open >= f_ext) ? f_open : f_ext;
    h_val = ZERO;
    if (diag  > h_val) h_val = diag;
    if (e_val > h_val) h_val = e_val;
    if (f_val > h_val) h_val = f_val;
    // Strict compare: ties keep the earlier row.
    best_nx     = best;
    best_row_nx = best_row;
    if (h_val > best) begin
      best_nx     = h_val;
      best_row_nx = row_cnt;
    end
  end

  always_comb begin
    state_nx = state;
    if (clear_i) state_nx = ST_EMPTY;
    else begin
      case (state)
        ST_EMPTY:  if (left.q_valid) state_nx = ST_LOADED;
        ST_LOADED: if (left.t_valid && !left.t_last) state_nx = ST_RUN;
        ST_RUN:    if (left.t_valid && left.t_last) state_nx = ST_LOADED;
        default:   state_nx = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_EMPTY;
    else        state <= state_nx;
  end

  // Cell-internal recurrence state; returns to first-row values after t_last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_sym_r  <= '0;
      h_diag   <= ZERO;
      h_up     <= ZERO;
      f_up     <= NEG_INF;
      best     <= ZERO;
      best_row <= '0;
      row_cnt  <= '0;
    end else if (clear_i) begin
      q_sym_r  <= '0;
      h_diag   <= ZERO;
      h_up     <= ZERO;
      f_up     <= NEG_INF;
      best     <= ZERO;
      best_row <= '0;
      row_cnt  <= '0;
    end else begin
      if ((state == ST_EMPTY) && left.q_valid) q_sym_r <= left.q_sym;
      if (beat) begin
        if (left.t_last) begin
          h_diag   <= ZERO;
          h_up     <= ZERO;
          f_up     <= NEG_INF;
          best     <= ZERO;
          best_row <= '0;
          row_cnt  <= '0;
        end else begin
          h_diag   <= left.h;
          h_up     <= h_val;
          f_up     <= f_val;
          best     <= best_nx;
          best_row <= best_row_nx;
          row_cnt  <= (&row_cnt) ? row_cnt : row_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || clear_i) begin
      right.q_valid <= 1'b0;
      right.q_sym   <= '0;
      right.t_valid <= 1'b0;
      right.t_sym   <= '0;
      right.t_last  <= 1'b0;
      right.h       <= ZERO;
      right.e       <= ZERO;
      right.max     <= ZERO;
      right.max_row <= '0;
      right.max_col <= '0;
    end else begin
      right.q_valid <= left.q_valid && (state != ST_EMPTY);
      right.q_sym   <= left.q_sym;
      right.t_valid <= left.t_valid;
      right.t_sym   <= left.t_sym;
      right.t_last  <= left.t_last;
      if (state == ST_EMPTY) begin
        right.h       <= left.h;
        right.e       <= left.e;
        right.max     <= left.max;
        right.max_row <= left.max_row;
        right.max_col <= left.max_col;
      end else begin
        right.h <= h_val;
        right.e <= e_val;
        if (best_nx > left.max) begin
          right.max     <= best_nx;
          right.max_row <= best_row_nx;
          right.max_col <= COL_ID;
        end else begin
          right.max     <= left.max;
          right.max_row <= left.max_row;
          right.max_col <= left.max_col;
        end
      end
    end
  end

`ifdef SW_PE_TRACE_EN
  h_src_t h_src;

  always_comb begin
    h_src = SRC_ZERO;
    if (h_val > ZERO) begin
      if (diag == h_val)       h_src = SRC_DIAG;
      else if (e_val == h_val) h_src = SRC_E;
      else                     h_src = SRC_F;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || clear_i)     trace_o <= 4'd0;
    else if (state == ST_EMPTY) trace_o <= 4'd0;
    else                       trace_o <= {(f_open >= f_ext), (e_open >= e_ext), h_src};
  end
`endif

endmodule

// File: tb/tb_sw_pe_affine.sv
// tb/tb_sw_pe_affine.sv - directed bench: 2-PE chain plus an 8-bit PE for saturation
module tb_sw_pe_affine;
  import sw_pe_affine_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic signed [9:0] match_s = 10'sd2, mismatch_s = -10'sd1, open_s = -10'sd3, ext_s = -10'sd1;
  logic signed [7:0] m8 = 8'sd2, mm8 = -8'sd1, o8 = -8'sd3, x8 = -8'sd1;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sw_pe_affine_if #(.CALC_W(10)) l0();
  sw_pe_affine_if #(.CALC_W(10)) l1();
  sw_pe_affine_if #(.CALC_W(10)) l2();
  sw_pe_affine_if #(.CALC_W(8))  s_in();
  sw_pe_affine_if #(.CALC_W(8))  s_out();

`ifdef SW_PE_TRACE_EN
  logic [3:0] tr0, tr1, tr8;
`endif

  sw_pe_affine #(.CALC_W(10), .COL_IDX(0)) u_pe0 (
    .clk(clk), .rst_n(rst_n), .clear_i(clear),
    .match_i(match_s), .mismatch_i(mismatch_s), .gap_open_i(open_s), .gap_ext_i(ext_s),
    .left(l0), .right(l1)
`ifdef SW_PE_TRACE_EN
    , .trace_o(tr0)
`endif
  );

  sw_pe_affine #(.CALC_W(10), .COL_IDX(1)) u_pe1 (
    .clk(clk), .rst_n(rst_n), .clear_i(clear),
    .match_i(match_s), .mismatch_i(mismatch_s), .gap_open_i(open_s), .gap_ext_i(ext_s),
    .left(l1), .right(l2)
`ifdef SW_PE_TRACE_EN
    , .trace_o(tr1)
`endif
  );

  sw_pe_affine #(.CALC_W(8), .COL_IDX(0)) u_sat (
    .clk(clk), .rst_n(rst_n), .clear_i(clear),
    .match_i(m8), .mismatch_i(mm8), .gap_open_i(o8), .gap_ext_i(x8),
    .left(s_in), .right(s_out)
`ifdef SW_PE_TRACE_EN
    , .trace_o(tr8)
`endif
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_l0();
    l0.q_valid = 1'b0; l0.q_sym = '0;
    l0.t_valid = 1'b0; l0.t_sym = '0; l0.t_last = 1'b0;
    l0.h = '0; l0.e = 10'h200; l0.max = '0; l0.max_row = '0; l0.max_col = '0;
  endtask

  initial begin
    idle_l0();
    s_in.q_valid = 1'b0; s_in.q_sym = '0;
    s_in.t_valid = 1'b0; s_in.t_sym = '0; s_in.t_last = 1'b0;
    s_in.h = '0; s_in.e = 8'h80; s_in.max = '0; s_in.max_row = '0; s_in.max_col = '0;

    // Reset held while the left side is active
    l0.t_valid = 1'b1; l0.h = 10'sd5; l0.q_valid = 1'b1; l0.q_sym = 2'd3;
    tick(); tick();
    chk("rst_t_valid", l1.t_valid, 0);
    chk("rst_h", l1.h, 0);
    chk("rst_q_valid", l1.q_valid, 0);
    chk("rst_max", l2.max, 0);
    chk("rst_state", u_pe0.state, ST_EMPTY);
    idle_l0();
    rst_n = 1'b1;
    tick();

    // Fill chain: sym 2 then sym 1
    l0.q_valid = 1'b1; l0.q_sym = 2'd2;
    tick();
    chk("fill_hold_q_valid", l1.q_valid, 0);
    chk("fill_hold_sym", u_pe0.q_sym_r, 2);
    l0.q_sym = 2'd1;
    tick();
    chk("fill_fwd_q_valid", l1.q_valid, 1);
    chk("fill_fwd_sym", l1.q_sym, 1);
    l0.q_valid = 1'b0;
    tick();
    chk("fill_pe1_loaded", u_pe1.state, ST_LOADED);
    chk("fill_pe1_no_fwd", l2.q_valid, 0);

    // Partial stream to build up a local best before clearing
    l0.t_valid = 1'b1; l0.t_sym = 2'd2; l0.h = 10'sd5;
    tick();
    chk("pre_h0", l1.h, 2);
    chk("pre_e0", l1.e, 2);
    l0.h = '0;
    tick();
    chk("pre_h1", l1.h, 7);
    chk("pre_max1", l1.max, 7);
    chk("pre_row1", l1.max_row, 1);

    // Clear together with a target beat and a query symbol
    clear = 1'b1; l0.q_valid = 1'b1; l0.q_sym = 2'd3;
    tick();
    chk("clr_t_valid", l1.t_valid, 0);
    chk("clr_q_valid", l1.q_valid, 0);
    chk("clr_pe1_t_valid", l2.t_valid, 0);
    chk("clr_state0", u_pe0.state, ST_EMPTY);
    chk("clr_state1", u_pe1.state, ST_EMPTY);
    clear = 1'b0;
    idle_l0();

    // Reload query A, C
    l0.q_valid = 1'b1; l0.q_sym = 2'd0;
    tick();
    l0.q_sym = 2'd1;
    tick();
    l0.q_valid = 1'b0;
    tick();

    // Target A, C with t_last on C
    l0.t_valid = 1'b1; l0.t_sym = 2'd0;
    tick();
    chk("aln_pe0_h0", l1.h, 2);
    chk("aln_pe0_e0", l1.e, -3);
    l0.t_sym = 2'd1; l0.t_last = 1'b1;
    tick();
    chk("aln_pe0_h1", l1.h, 0);
    chk("aln_pe0_max", l1.max, 2);
    chk("aln_pe0_row", l1.max_row, 0);
    chk("aln_pe1_h0", l2.h, 0);
    l0.t_valid = 1'b0; l0.t_last = 1'b0;
    tick();
    chk("aln_pe1_h1", l2.h, 4);
    chk("aln_pe1_last", l2.t_last, 1);
    chk("aln_pe1_max", l2.max, 4);
    chk("aln_pe1_row", l2.max_row, 1);
    chk("aln_pe1_col", l2.max_col, 1);
    chk("aln_pe0_state", u_pe0.state, ST_LOADED);

    // Single-row stream: best must have restarted at 0
    l0.t_valid = 1'b1; l0.t_sym = 2'd1; l0.t_last = 1'b1;
    tick();
    chk("new_stream_h", l1.h, 0);
    chk("new_stream_max", l1.max, 0);
    l0.t_valid = 1'b0; l0.t_last = 1'b0;
    tick();

    // Asynchronous reset mid-stream
    l0.t_valid = 1'b1; l0.t_sym = 2'd0;
    tick();
    chk("mid_pre_max", l1.max, 2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_t_valid", l1.t_valid, 0);
    chk("mid_rst_h", l1.h, 0);
    chk("mid_rst_max", l1.max, 0);
    chk("mid_rst_state", u_pe0.state, ST_EMPTY);
    l0.t_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Bypass through two EMPTY PEs
    l0.t_valid = 1'b1; l0.t_sym = 2'd3; l0.t_last = 1'b1;
    l0.h = 10'sd5; l0.e = -10'sd3; l0.max = 10'sd7; l0.max_row = 16'd9; l0.max_col = 10'd2;
    tick();
    chk("byp_t_valid", l1.t_valid, 1);
    chk("byp_t_sym", l1.t_sym, 3);
    chk("byp_h", l1.h, 5);
    chk("byp_e", l1.e, -3);
    chk("byp_max", l1.max, 7);
    chk("byp_row", l1.max_row, 9);
    chk("byp_col", l1.max_col, 2);
    idle_l0();
    tick();
    chk("byp2_h", l2.h, 5);
    chk("byp2_max", l2.max, 7);
    chk("byp_state", u_pe0.state, ST_EMPTY);

    // First query symbol after reset is captured, not forwarded
    l0.q_valid = 1'b1; l0.q_sym = 2'd3;
    tick();
    chk("post_rst_q_valid", l1.q_valid, 0);
    chk("post_rst_sym", u_pe0.q_sym_r, 3);
    l0.q_valid = 1'b0;
    tick();

    // Saturation on the 8-bit PE
    s_in.q_valid = 1'b1; s_in.q_sym = 2'd0;
    tick();
    s_in.q_valid = 1'b0;
    s_in.t_valid = 1'b1; s_in.t_sym = 2'd1; s_in.h = 8'sd126; s_in.e = 8'h80;
    tick();
    chk("sat_h0", s_out.h, 123);
    s_in.t_sym = 2'd0; s_in.h = 8'h80;
    tick();
    chk("sat_h1", s_out.h, 127);
    chk("sat_e1", s_out.e, -128);
    s_in.t_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sw_pe_affine.md
# sw_pe_affine

Parametrised systolic Smith-Waterman processing element with affine gap penalties, the next-generation cell for the alignment array. Each instance holds one query symbol (one matrix column), scores a streamed target (one row per valid beat), and forwards scores, target symbols and a running best-score reduction to its right neighbour. Compared with the previous cell it adds:

- configurable score and symbol widths;
- saturating arithmetic;
- self-loading query fill chain;
- bypass when unloaded;
- row/column tracking of the best score.

## Interface
- CALC_W, 10: signed score width (two's complement).
- SYM_W, 2: symbol width (2 = DNA, 5 = protein).
- ROW_W, 16: row-counter width.
- COL_IDX, 0: this PE's column index, reported with the best score.
- COL_W, 10: column-index width.
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- clear_i  in  1  synchronous flush: state to EMPTY, best and row cleared.
- match_i, mismatch_i  in  CALC_W  substitution scores (signed).
- gap_open_i  in  CALC_W  cost of the first gap position (negative).
- gap_ext_i  in  CALC_W  cost of each further gap position (negative).
- q_valid_i, q_sym_i  in  1, SYM_W  query fill chain input.
- q_valid_o, q_sym_o  out  1, SYM_W  query fill chain output.
- t_valid_i, t_sym_i, t_last_i  in  1, SYM_W, 1  target beat; t_last_i marks the final row.
- h_i, e_i  in  CALC_W  H(i,j-1) and E(i,j-1) from the left, aligned with t_valid_i.
- max_i, max_row_i, max_col_i  in  CALC_W, ROW_W, COL_W  best score so far from the left.
- t_valid_o, t_sym_o, t_last_o, h_o, e_o, max_o, max_row_o, max_col_o  out  same widths  registered right-neighbour copies.

## Operation
- **States.**
  - EMPTY: reset and clear_i target.
  - LOADED: query held, idle.
  - RUN: inside a target stream.
- **Transitions.**
  - EMPTY→LOADED on q_valid_i.
  - LOADED→RUN on t_valid_i.
  - RUN→LOADED on a valid beat with t_last_i.
  - Any→EMPTY on clear_i.
- **Fill chain.**
  - In EMPTY, q_valid_i captures q_sym_i and nothing is forwarded.
  - Otherwise q_valid_i/q_sym_i are forwarded to q_*_o one cycle later.
- **Scoring** (loaded, valid beat). All adds and max operations are signed.
  - s = match_i if t_sym_i == q_sym (all SYM_W bits), else mismatch_i.
  - E = max(h_i+gap_open_i, e_i+gap_ext_i).
  - F = max(h_up+gap_open_i, f_up+gap_ext_i).
  - H = max(0, h_diag+s, E, F).
- **Internal registers.**
  - h_diag = previous beat's h_i.
  - h_up and f_up = this PE's previous H and F.
  - On the first beat after EMPTY/LOADED: h_diag = 0, h_up = 0, f_up = NEG_INF.
- **Outputs.** h_o = H; e_o = E; t_* forwarded unchanged.
- **Saturation.**
  - Every add saturates to [NEG_INF = -2^(CALC_W-1), 2^(CALC_W-1)-1] and never wraps.
  - The left driver of PE 0 supplies h_i = 0 and e_i = NEG_INF.
- **Row counter.**
  - Counts valid beats in RUN, starting at 0 on the first beat.
  - Saturates at all-ones.
  - Returns to 0 after the t_last beat.
- **Best tracking.**
  - local best/row is updated when H > local best (strict).
  - max_* outputs carry local best (col = COL_IDX) only if local best > max_i (strict); otherwise they pass max_* inputs.
  - Ties keep the earlier row or left-most column.
  - local best resets to 0 after the t_last beat.
- **Bypass (EMPTY).**
  - t_*, h, e and max_* pass through with one-cycle delay.
  - No scoring; internal state is untouched.
- **Simultaneous events.**
  - clear_i wins over q_valid_i (symbol dropped, not forwarded).
  - clear_i wins over t_valid_i (t_valid_o = 0 next cycle).

## Timing
- All outputs are registered.
- Latency is 1 cycle for the data path, fill chain and max chain.
- Throughput is one beat per cycle. There is no back-pressure; t_valid_i may be high every cycle.
- Reset values:
  - every output 0;
  - state EMPTY;
  - internal registers 0, f_up = NEG_INF.
- rst_n assertion mid-stream aborts immediately. The query must be reloaded.
- A gap between valid beats (t_valid_i low) holds all internal state. The outputs' valid bit drops; their data are don't-care.

## Configuration
- SW_PE_TRACE_EN defined:
  - Adds output trace_o[3:0], registered alongside h_o.
  - [1:0] H source: 00 zero, 01 diag, 10 E, 11 F. Tie priority is diag > E > F; 00 when the maximum ≤ 0.
  - [2] E came from open; [3] F came from open (open wins ties).
  - Reset value 0.
- Undefined: trace_o port and logic absent; all other behaviour identical.

## Structure
- Shared package:
  - CALC_W/SYM_W defaults;
  - NEG_INF constant function;
  - state enum (EMPTY/LOADED/RUN);
  - trace-source encoding.
- One sub-module, sw_sat_add: signed saturating adder, used for all five additions.

## Test plan
- **Reset:** assert rst_n = 0 mid-activity → every output 0 and state EMPTY; the next q_valid_i is captured, not forwarded.
- **Fill chain:**
  - q_valid_i with sym 2, then sym 1, on one EMPTY PE → sym 2 held, q_valid_o = 0.
  - The following cycle → q_valid_o = 1, q_sym_o = 1.
- **Alignment, 2-PE chain:**
  - Setup: query A=0, C=1; match 2, mismatch -1, open -3, ext -1; target A,C with t_last on C.
  - PE0 h_o = 2, 0.
  - PE1 h_o = 0, 4.
  - With t_last_o: PE1 max_o = 4, max_row_o = 1, max_col_o = 1.
- **Saturation:** CALC_W = 8, h_diag = 126, match 2 → h_o = 127 (not -128).
- **Bypass:** EMPTY PE, t_valid_i with h_i = 5, e_i = -3, max_i = 7 → identical values on outputs 1 cycle later.
- **Clear mid-stream:** clear_i together with t_valid_i and q_valid_i → next cycle t_valid_o = 0, q_valid_o = 0, state EMPTY, max chain resumes from 0 after reload.
